quantum_scheduler: RTL and testbench

- Time-sliced round-robin scheduler sharing one resource among NUM_REQ requesters.
- Grants are registered, one-hot and preemptive. The owner is preempted after QUANTUM cycles only when another requester is waiting.
- A mandatory one-cycle HANDOFF gap separates any two owners, so ownership never overlaps.
- Sits between requester agents and the shared resource's enable/select mux.

---
 rtl/qsched_pkg.sv | 26 ++
 rtl/rr_pick.sv | 24 ++
 rtl/quantum_scheduler.sv | 105 ++++++++++
 tb/tb_quantum_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/qsched_pkg.sv
// Shared types and helpers for the quantum_scheduler time-sliced arbiter.
package qsched_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } state_t;

  // Index of the first set bit of req[n-1:0] at or after ptr, searching circularly; -1 if none.
  // Walk the offsets downward so the smallest offset is the last one written.
  function automatic int rr_first(input logic [MAX_REQ-1:0] req, input int n, input int ptr);
    int pos;
    int res;
    res = -1;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      pos = ptr + k;
      if (pos >= n) pos = pos - n;
      if (k < n && req[pos[3:0]]) res = pos;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first requester at or after ptr.
module rr_pick
  import qsched_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    pick,
  output logic [ID_W-1:0] idx,
  output logic            valid
);

  int first;

  always_comb begin
    first = rr_first(MAX_REQ'(req), N, int'(ptr));
    valid = (first >= 0);
    idx   = ID_W'(first);
    pick  = valid ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/quantum_scheduler.sv
// Preemptive round-robin scheduler with a QUANTUM time slice and a one-cycle handoff gap.
// Optional owner lock is enabled by defining QSCHED_LOCK_EN.
module quantum_scheduler
  import qsched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int QUANTUM = 8
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef QSCHED_LOCK_EN
  input  logic                       lock,
`endif
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       handoff
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(QUANTUM + 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ID_W-1:0]    ptr, ptr_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [ID_W-1:0]    id_n;
  logic [NUM_REQ-1:0] pick;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_valid;
  logic               hold;
  logic               others;

`ifdef QSCHED_LOCK_EN
  assign hold = lock;
`else
  assign hold = 1'b0;
`endif

  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .pick  (pick),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign others  = |(req & ~grant);
  assign busy    = |grant;
  assign handoff = (state == HANDOFF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      grant    <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      grant    <= grant_n;
      grant_id <= id_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    grant_n = grant;
    id_n    = grant_id;
    case (state)
      IDLE, HANDOFF: begin
        if (pick_valid) begin
          state_n = GRANT;
          grant_n = pick;
          id_n    = pick_idx;
          cnt_n   = CNT_W'(1);
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        // Leaving GRANT always advances the pointer past the owner so it ranks last next time.
        if (!req[grant_id] || (cnt == CNT_W'(QUANTUM) && !hold && others)) begin
          state_n = HANDOFF;
          grant_n = '0;
          ptr_n   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end else if (cnt == CNT_W'(QUANTUM)) begin
          cnt_n = hold ? cnt : CNT_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed self-checking bench for quantum_scheduler (NUM_REQ=4, QUANTUM=8).
module tb_quantum_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       handoff;
`ifdef QSCHED_LOCK_EN
  logic       lock;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  quantum_scheduler #(.NUM_REQ(4), .QUANTUM(8)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef QSCHED_LOCK_EN
    .lock     (lock),
`endif
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .handoff  (handoff)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, and check the invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
    chk("busy_eq_or", 32'(busy), 32'(|grant));
    chk("no_ho_busy", 32'(handoff & busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_handoff", 32'(handoff), 32'd0);
    reset = 1'b1;
  endtask

  // Each round: 8 grant cycles for the expected owner, then one gap cycle.
  task automatic run_rounds(input int n_rounds, input int n_owners);
    int own;
    for (int r = 0; r < n_rounds; r++) begin
      own = r % n_owners;
      for (int c = 0; c < 8; c++) begin
        tick();
        chk("rr_grant", 32'(grant), 32'(4'b0001 << own));
        chk("rr_id", 32'(grant_id), 32'(own));
        chk("rr_no_ho", 32'(handoff), 32'd0);
      end
      tick();
      chk("rr_gap_grant", 32'(grant), 32'd0);
      chk("rr_gap_ho", 32'(handoff), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'b0000;
`ifdef QSCHED_LOCK_EN
    lock  = 1'b0;
`endif

    // Sole requester keeps the grant across quantum reloads; a non-owner glitch is ignored.
    do_reset();
    req = 4'b0001;
    tick();
    chk("solo_first", 32'(grant), 32'h1);
    for (int i = 0; i < 20; i++) begin
      req = (i == 5) ? 4'b0101 : 4'b0001;
      tick();
      chk("solo_grant", 32'(grant), 32'h1);
      chk("solo_no_ho", 32'(handoff), 32'd0);
    end
    req = 4'b0000;
    tick();
    chk("solo_drop_grant", 32'(grant), 32'd0);
    chk("solo_drop_ho", 32'(handoff), 32'd1);
    tick();
    chk("solo_idle_ho", 32'(handoff), 32'd0);
    chk("solo_idle_id", 32'(grant_id), 32'd0);

    // Two requesters alternate every quantum.
    do_reset();
    req = 4'b0011;
    run_rounds(4, 2);

    // Owner 2 releases early while requester 0 waits.
    do_reset();
    req = 4'b0100;
    tick();
    chk("early_grant", 32'(grant), 32'h4);
    req = 4'b0101;
    tick();
    chk("early_c2", 32'(grant), 32'h4);
    tick();
    chk("early_c3", 32'(grant), 32'h4);
    req = 4'b0001;
    tick();
    chk("early_gap", 32'(grant), 32'd0);
    chk("early_gap_ho", 32'(handoff), 32'd1);
    tick();
    chk("early_next", 32'(grant), 32'h1);
    chk("early_next_id", 32'(grant_id), 32'd0);

    // All four requesting: order 0,1,2,3,0 with pointer wrap.
    do_reset();
    req = 4'b1111;
    run_rounds(5, 4);

    // Request arriving during the gap; then reset mid-grant.
    req = 4'b1000;
    tick();
    chk("gap_arrival", 32'(grant), 32'h8);
    chk("gap_arrival_id", 32'(grant_id), 32'd3);
    tick();
    chk("hold3", 32'(grant), 32'h8);
    reset = 1'b0;
    tick();
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ho", 32'(handoff), 32'd0);
    chk("midrst_id", 32'(grant_id), 32'd0);
    reset = 1'b1;
    req = 4'b1001;
    tick();
    chk("ptr_restart", 32'(grant), 32'h1);
    reset = 1'b0;
    tick();
    chk("rst2_grant", 32'(grant), 32'd0);
    reset = 1'b1;
    req = 4'b1000;
    tick();
    chk("regrant3", 32'(grant), 32'h8);
    chk("regrant3_id", 32'(grant_id), 32'd3);

`ifdef QSCHED_LOCK_EN
    // Locked owner ignores the quantum; unlocking with a waiter preempts at the next edge.
    do_reset();
    lock = 1'b1;
    req = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lock_grant", 32'(grant), 32'h1);
      chk("lock_no_ho", 32'(handoff), 32'd0);
    end
    lock = 1'b0;
    tick();
    chk("unlock_gap", 32'(grant), 32'd0);
    chk("unlock_ho", 32'(handoff), 32'd1);
    tick();
    chk("unlock_next", 32'(grant), 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
